// File: rtl/br_pred_scoreboard_pkg.sv
// Shared types, default widths and report helpers for the branch-predictor scoreboard.
package br_pred_scoreboard_pkg;

   localparam int unsigned CNT_W_DEF = 32;
   localparam int unsigned RUN_W_DEF = 16;

   typedef struct packed {
      logic [CNT_W_DEF-1:0] br;
      logic [CNT_W_DEF-1:0] hit;
      logic [CNT_W_DEF-1:0] miss;
      logic [RUN_W_DEF-1:0] cur_run;
      logic [RUN_W_DEF-1:0] max_run;
      logic                 sat;
   } br_stats_t;

   function automatic real acc_pct(input longint unsigned hit, input longint unsigned total);
      if (total == 0) return 0.0;
      return 100.0 * real'(hit) / real'(total);
   endfunction

endpackage

// File: rtl/br_pred_scoreboard_sat_counter.sv
// Up-counter that sticks at all-ones; clear has priority over enable.
module br_pred_scoreboard_sat_counter #(
   parameter int unsigned W = 8
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_en,
   input  logic         i_clr,
   output logic [W-1:0] o_cnt,
   output logic         o_at_max
);

   logic [W-1:0] r_cnt;

   assign o_cnt    = r_cnt;
   assign o_at_max = &r_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en && !o_at_max) begin
         r_cnt <= r_cnt + W'(1);
      end
   end

endmodule

// File: rtl/br_pred_scoreboard.sv
// Passive branch-predictor monitor: hit/miss counters, miss-run tracking and an end-of-run report.
module br_pred_scoreboard
   import br_pred_scoreboard_pkg::*;
#(
   parameter int unsigned CNT_W   = CNT_W_DEF,
   parameter int unsigned RUN_W   = RUN_W_DEF,
   parameter bit          VERBOSE = 1'b0
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_is_br,
   input  logic             i_is_correct,
   output logic [CNT_W-1:0] o_br_cnt,
   output logic [CNT_W-1:0] o_hit_cnt,
   output logic [CNT_W-1:0] o_miss_cnt,
   output logic [RUN_W-1:0] o_cur_miss_run,
   output logic [RUN_W-1:0] o_max_miss_run,
   output logic             o_sat
);

   logic             w_hit;
   logic             w_miss;
   logic             w_br_max;
   logic             w_hit_max;
   logic             w_miss_max;
   logic             w_run_max;
   logic             w_any_max;
   logic [RUN_W-1:0] w_next_run;
   logic [RUN_W-1:0] r_max_run;
   logic             r_sat;

   // i_is_correct only matters when a branch is present
   assign w_hit  = i_is_br & i_is_correct;
   assign w_miss = i_is_br & ~i_is_correct;

   br_pred_scoreboard_sat_counter #(.W(CNT_W)) u_br_cnt (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_en     (i_is_br),
      .i_clr    (1'b0),
      .o_cnt    (o_br_cnt),
      .o_at_max (w_br_max)
   );

   br_pred_scoreboard_sat_counter #(.W(CNT_W)) u_hit_cnt (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_en     (w_hit),
      .i_clr    (1'b0),
      .o_cnt    (o_hit_cnt),
      .o_at_max (w_hit_max)
   );

   br_pred_scoreboard_sat_counter #(.W(CNT_W)) u_miss_cnt (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_en     (w_miss),
      .i_clr    (1'b0),
      .o_cnt    (o_miss_cnt),
      .o_at_max (w_miss_max)
   );

   br_pred_scoreboard_sat_counter #(.W(RUN_W)) u_run_cnt (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_en     (w_miss),
      .i_clr    (w_hit),
      .o_cnt    (o_cur_miss_run),
      .o_at_max (w_run_max)
   );

   // Mirror of the run counter's next value so max tracks it in the same cycle
   always_comb begin
      w_next_run = o_cur_miss_run;
      if (w_hit) begin
         w_next_run = '0;
      end else if (w_miss && !w_run_max) begin
         w_next_run = o_cur_miss_run + RUN_W'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_max_run <= '0;
      end else if (w_next_run > r_max_run) begin
         r_max_run <= w_next_run;
      end
   end

   assign w_any_max = w_br_max | w_hit_max | w_miss_max | w_run_max;

   // The run counter can fall back from all-ones, so the flag needs its own sticky bit
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sat <= 1'b0;
      end else begin
         r_sat <= r_sat | w_any_max;
      end
   end

   assign o_max_miss_run = r_max_run;
   assign o_sat          = r_sat | w_any_max;

`ifndef SYNTHESIS
   br_stats_t w_stats;

   always_comb begin
      w_stats         = '0;
      w_stats.br      = CNT_W_DEF'(o_br_cnt);
      w_stats.hit     = CNT_W_DEF'(o_hit_cnt);
      w_stats.miss    = CNT_W_DEF'(o_miss_cnt);
      w_stats.cur_run = RUN_W_DEF'(o_cur_miss_run);
      w_stats.max_run = RUN_W_DEF'(o_max_miss_run);
      w_stats.sat     = o_sat;
   end

   always @(posedge i_clk) begin
      if (i_rst_n) begin
         if ($isunknown(i_is_br)) begin
            $warning("BR_PRED: unknown i_is_br at %0t, cycle ignored", $time);
         end
         if (!o_sat && (o_br_cnt != CNT_W'(o_hit_cnt + o_miss_cnt))) begin
            $error("BR_PRED: br=%0d != hit=%0d + miss=%0d", o_br_cnt, o_hit_cnt, o_miss_cnt);
         end
         if (VERBOSE && w_miss === 1'b1) begin
            $display("BR_PRED: miss at %0t br=%0d hit=%0d miss=%0d run=%0d", $time,
                     o_br_cnt + CNT_W'(1), o_hit_cnt, o_miss_cnt + CNT_W'(1), w_next_run);
         end
      end
   end

   final begin
      if (w_stats.br == 0) begin
         $display("BR_PRED: no branches executed");
      end else if (w_stats.sat) begin
         $display("BR_PRED: total=%0d hit=%0d miss=%0d acc=%0.2f%% maxrun=%0d (SATURATED)",
                  w_stats.br, w_stats.hit, w_stats.miss,
                  acc_pct(64'(w_stats.hit), 64'(w_stats.br)), w_stats.max_run);
      end else begin
         $display("BR_PRED: total=%0d hit=%0d miss=%0d acc=%0.2f%% maxrun=%0d",
                  w_stats.br, w_stats.hit, w_stats.miss,
                  acc_pct(64'(w_stats.hit), 64'(w_stats.br)), w_stats.max_run);
      end
   end
`endif

endmodule

// File: tb/tb_br_pred_scoreboard.sv
// Bench for br_pred_scoreboard: vector table, async-reset and saturation sequences, random vs model.
module tb_br_pred_scoreboard;
   import br_pred_scoreboard_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n, is_br, is_cor;
   logic [31:0] a_br, a_hit, a_miss;
   logic [15:0] a_cur, a_max;
   logic        a_sat;

   logic        b_rst_n, b_is_br, b_is_cor;
   logic [3:0]  b_br, b_hit, b_miss;
   logic [15:0] b_cur, b_max;
   logic        b_sat;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      bit rst;
      bit br;
      bit cor;
      int e_br, e_hit, e_miss, e_cur, e_max;
   } vec_t;

   vec_t vecs[$];
   bit   hist[$];

   always #5 clk = ~clk;

   br_pred_scoreboard u_dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_is_br        (is_br),
      .i_is_correct   (is_cor),
      .o_br_cnt       (a_br),
      .o_hit_cnt      (a_hit),
      .o_miss_cnt     (a_miss),
      .o_cur_miss_run (a_cur),
      .o_max_miss_run (a_max),
      .o_sat          (a_sat)
   );

   br_pred_scoreboard #(.CNT_W(4)) u_dut_sat (
      .i_clk          (clk),
      .i_rst_n        (b_rst_n),
      .i_is_br        (b_is_br),
      .i_is_correct   (b_is_cor),
      .o_br_cnt       (b_br),
      .o_hit_cnt      (b_hit),
      .o_miss_cnt     (b_miss),
      .o_cur_miss_run (b_cur),
      .o_max_miss_run (b_max),
      .o_sat          (b_sat)
   );

   task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input int br, input int hit, input int miss,
                          input int cur, input int mx, input bit sat);
      chk({tag, ".br"},   a_br,   br);
      chk({tag, ".hit"},  a_hit,  hit);
      chk({tag, ".miss"}, a_miss, miss);
      chk({tag, ".cur"},  a_cur,  cur);
      chk({tag, ".max"},  a_max,  mx);
      chk({tag, ".sat"},  a_sat,  sat);
   endtask

   task automatic step(input bit br, input logic cor);
      is_br  = br;
      is_cor = cor;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic rst_pulse();
      is_br = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic add(input bit rst, input bit br, input bit cor, input int e_br, input int e_hit,
                      input int e_miss, input int e_cur, input int e_max);
      vec_t v;
      v.rst = rst; v.br = br; v.cor = cor;
      v.e_br = e_br; v.e_hit = e_hit; v.e_miss = e_miss; v.e_cur = e_cur; v.e_max = e_max;
      vecs.push_back(v);
   endtask

   // Reference statistics derived from the list of branch outcomes since reset
   task automatic model(output int br, output int hit, output int miss, output int cur,
                        output int mx);
      int run;
      br = hist.size(); hit = 0; miss = 0; cur = 0; mx = 0; run = 0;
      foreach (hist[k]) begin
         if (hist[k]) begin
            hit++;
            run = 0;
         end else begin
            miss++;
            run++;
            if (run > mx) mx = run;
         end
      end
      cur = run;
   endtask

   initial begin
      int e_br, e_hit, e_miss, e_cur, e_max;
      bit br, cor;

      rst_n = 1'b0; is_br = 1'b0; is_cor = 1'b0;
      b_rst_n = 1'b0; b_is_br = 1'b0; b_is_cor = 1'b0;

      // Held in reset for 55 time units with no branches
      #50;
      chk_all("in_reset", 0, 0, 0, 0, 0, 0);
      #5;
      rst_n = 1'b1;
      b_rst_n = 1'b1;
      @(negedge clk);
      chk_all("post_reset", 0, 0, 0, 0, 0, 0);

      // Ten correct predictions
      for (int i = 1; i <= 10; i++) add(i == 1, 1, 1, i, i, 0, 0, 0);
      // correct, wrong, wrong, wrong, correct, wrong
      add(1, 1, 1, 1, 1, 0, 0, 0);
      add(0, 1, 0, 2, 1, 1, 1, 1);
      add(0, 1, 0, 3, 1, 2, 2, 2);
      add(0, 1, 0, 4, 1, 3, 3, 3);
      add(0, 1, 1, 5, 2, 3, 0, 3);
      add(0, 1, 0, 6, 2, 4, 1, 3);
      // No branches: state holds whatever i_is_correct does
      for (int i = 0; i < 20; i++) add(0, 0, i[0], 6, 2, 4, 1, 3);

      foreach (vecs[i]) begin
         if (vecs[i].rst) rst_pulse();
         step(vecs[i].br, (!vecs[i].br && i % 4 == 0) ? 1'bx : logic'(vecs[i].cor));
         chk_all($sformatf("vec%0d", i), vecs[i].e_br, vecs[i].e_hit, vecs[i].e_miss,
                 vecs[i].e_cur, vecs[i].e_max, 0);
      end

      // Asynchronous reset in the middle of a cycle
      rst_pulse();
      repeat (3) step(1, 0);
      chk_all("three_miss", 3, 0, 3, 3, 3, 0);
      is_br = 1'b0;
      #2 rst_n = 1'b0;
      #1 chk_all("async_rst", 0, 0, 0, 0, 0, 0);
      #1 rst_n = 1'b1;
      @(negedge clk);
      repeat (4) step(1, 1);
      step(1, 0);
      chk_all("after_rst", 5, 4, 1, 1, 1, 0);
      chk("acc_pct_80", longint'(int'(acc_pct(4, 5) * 100.0)), 8000);

      // Random traffic against the outcome-list model
      rst_pulse();
      hist.delete();
      for (int i = 0; i < 400; i++) begin
         br  = ($urandom_range(0, 3) != 0);
         cor = ($urandom_range(0, 1) != 0);
         step(br, cor);
         if (br) hist.push_back(cor);
         model(e_br, e_hit, e_miss, e_cur, e_max);
         chk_all($sformatf("rnd%0d", i), e_br, e_hit, e_miss, e_cur, e_max, 0);
      end

      // 4-bit counters: 17 hits saturate br and hit at 15
      is_br = 1'b0;
      b_is_br = 1'b1;
      b_is_cor = 1'b1;
      for (int i = 1; i <= 17; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("sat%0d.br", i),   b_br,   (i > 15) ? 15 : i);
         chk($sformatf("sat%0d.hit", i),  b_hit,  (i > 15) ? 15 : i);
         chk($sformatf("sat%0d.miss", i), b_miss, 0);
         chk($sformatf("sat%0d.max", i),  b_max,  0);
         chk($sformatf("sat%0d.sat", i),  b_sat,  i >= 15);
      end
      b_is_br = 1'b0;
      repeat (2) @(negedge clk);
      chk("sat_sticky", b_sat, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
